// File: rtl/cpu_bus_responder.sv
// CPU external-bus responder for one RAM window: address decode, RAM mirroring,
// configurable wait-state stretching via rdy, and a sticky protocol-error flag.
module cpu_bus_responder #(
    parameter int unsigned               ADDR_WIDTH  = 16,
    parameter int unsigned               DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR   = 16'h0000,
    parameter logic [ADDR_WIDTH-1:0]     WINDOW_SIZE = 16'h2000,
    parameter int unsigned               RAM_DEPTH   = 2048,
    parameter int unsigned               WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cycle_start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  r_w_n,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  d_oe,
    output logic                  rdy,
    output logic                  hit,
    output logic                  bus_err
);

    localparam int unsigned IDX_W = $clog2(RAM_DEPTH);
    localparam logic ZERO_WAIT_C  = (WAIT_STATES == 0);
    localparam logic [ADDR_WIDTH:0] BASE_EXT_C = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] SIZE_EXT_C = {1'b0, WINDOW_SIZE};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic                    rw_r;
    logic [DATA_WIDTH-1:0]   d_out_r;
    logic                    d_oe_r;
    logic                    rdy_r;
    logic                    hit_r;
    logic                    bus_err_r;
    logic [DATA_WIDTH-1:0]   mem_r [RAM_DEPTH];

    logic [ADDR_WIDTH:0]     offset_s;
    logic                    sel_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    in_wait_s;
    logic                    access_now_s;
    logic [IDX_W-1:0]        acc_idx_s;
    logic                    acc_rd_s;
    logic                    wr_en_s;

    // Decode, RAM index and access-edge selection; an address below the base
    // wraps the widened offset far above any window size, so one compare suffices
    always_comb begin
        offset_s     = {1'b0, addr} - BASE_EXT_C;
        sel_s        = (offset_s < SIZE_EXT_C);
        idx_s        = addr[IDX_W-1:0] - BASE_ADDR[IDX_W-1:0];
        in_wait_s    = (state_r == ST_WAIT);
        access_now_s = in_wait_s ? (cnt_r == 4'd1)
                                 : (cycle_start && sel_s && ZERO_WAIT_C);
        acc_idx_s    = in_wait_s ? idx_r : idx_s;
        acc_rd_s     = in_wait_s ? rw_r  : r_w_n;
        wr_en_s      = access_now_s && !acc_rd_s && !reset;
    end

    // Single RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[acc_idx_s] <= d_in;
        end
    end

    // Bus-cycle FSM with registered bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            idx_r     <= '0;
            rw_r      <= 1'b1;
            d_out_r   <= '0;
            d_oe_r    <= 1'b0;
            rdy_r     <= 1'b1;
            hit_r     <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (cycle_start) begin
                        if (sel_s) begin
                            idx_r  <= idx_s;
                            rw_r   <= r_w_n;
                            hit_r  <= 1'b1;
                            d_oe_r <= 1'b0;
                            if (ZERO_WAIT_C) begin
                                if (r_w_n) begin
                                    d_out_r <= mem_r[idx_s];
                                    d_oe_r  <= 1'b1;
                                end
                                rdy_r   <= 1'b1;
                                state_r <= ST_HOLD;
                            end else begin
                                cnt_r   <= 4'(WAIT_STATES);
                                rdy_r   <= 1'b0;
                                state_r <= ST_WAIT;
                            end
                        end else begin
                            hit_r   <= 1'b0;
                            d_oe_r  <= 1'b0;
                            rdy_r   <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    // A new cycle while stalled is a CPU protocol violation
                    if (cycle_start) begin
                        bus_err_r <= 1'b1;
                    end
                    if (cnt_r == 4'd1) begin
                        if (rw_r) begin
                            d_out_r <= mem_r[idx_r];
                            d_oe_r  <= 1'b1;
                        end
                        cnt_r   <= 4'd0;
                        rdy_r   <= 1'b1;
                        state_r <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    rdy_r   <= 1'b1;
                    d_oe_r  <= 1'b0;
                    hit_r   <= 1'b0;
                end
            endcase
        end
    end

    assign d_out   = d_out_r;
    assign d_oe    = d_oe_r;
    assign rdy     = rdy_r;
    assign hit     = hit_r;
    assign bus_err = bus_err_r;

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
Target-side (responder) end of the CPU external bus: services the CPU's address/R_W_n/data transactions for one memory-mapped RAM window.
- Decodes a configurable address window and mirrors a smaller internal RAM across it (NES-style 2 KB RAM mirrored over $0000-$1FFF).
- Stretches accesses with a configurable number of wait states by holding rdy low.
- Sits between the board-level bus and the CPU's A/D/R_W_n/rdy pins; one instance per RAM region.

Parameters:
ADDR_WIDTH, 16, CPU address width
DATA_WIDTH, 8, CPU data width
BASE_ADDR, 16'h0000, first address of the decoded window
WINDOW_SIZE, 16'h2000, window length in bytes; power of two, ≥ RAM_DEPTH
RAM_DEPTH, 2048, internal RAM bytes; power of two; mirrored every RAM_DEPTH bytes inside the window
WAIT_STATES, 0, extra cycles per access, range 0..15

Ports:
clk  input  1  bus clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
cycle_start  input  1  one-clk strobe: addr/r_w_n valid, new bus cycle begins
addr  input  ADDR_WIDTH  CPU address
r_w_n  input  1  1 = read, 0 = write
d_in  input  DATA_WIDTH  write data from CPU
d_out  output  DATA_WIDTH  read data to CPU
d_oe  output  1  responder drives data bus (tristate enable at top level)
rdy  output  1  0 = CPU must stall
hit  output  1  current cycle decoded to this responder
bus_err  output  1  sticky protocol-violation flag

Behaviour:
- Decode: sel = (addr >= BASE_ADDR) && (addr < BASE_ADDR + WINDOW_SIZE); computed in full ADDR_WIDTH+1 width, so no wrap at the top of the address space.
- RAM index = (addr - BASE_ADDR) mod RAM_DEPTH, i.e. the low log2(RAM_DEPTH) bits. Mirrors alias the same byte.
- States: IDLE, WAIT, HOLD.
- IDLE or HOLD, cycle_start=1 at edge T0:
  - sel=0: hit<=0, d_oe<=0, state IDLE.
  - sel=1: latch index and r_w_n; hit<=1; d_oe<=0.
  - sel=1 and WAIT_STATES=0: access performed at T0. Read: d_out<=mem[index], d_oe<=1. Write: mem[index]<=d_in sampled at T0. Next state HOLD; rdy stays 1.
  - sel=1 and WAIT_STATES=N>0: cnt<=N, rdy<=0, next state WAIT.
- WAIT: cnt decrements each edge.
  - At the edge where cnt==1: access performed (read loads d_out and sets d_oe; write commits d_in sampled at that edge), rdy<=1, next state HOLD.
  - Read data is valid after edge T0+N; rdy is low for exactly N cycles.
- HOLD: d_out/d_oe/hit held until the next cycle_start. Writes leave d_oe=0.
- cycle_start in WAIT: ignored (the latched access continues unchanged), bus_err<=1. bus_err is cleared only by reset.
- Read and write never occur in the same edge; there is a single RAM port.
- Reset (asynchronous, any state, including mid-WAIT):
  - state IDLE, rdy=1, d_oe=0, d_out=0, hit=0, bus_err=0, cnt=0.
  - A pending write is dropped.
  - RAM contents are not cleared.
- d_out changes only on an access edge or reset. It never glitches while d_oe=1.

Test Plan:
- WAIT_STATES=0: write $5A to $0010, then read $0010 -> after read edge d_oe=1, d_out=$5A, rdy constant 1.
- Mirroring: write $A5 to $0801, read $1801 and $0001 -> both return $A5. Read $2000 -> hit=0, d_oe=0, rdy=1.
- WAIT_STATES=3: read $0010 -> rdy low exactly 3 cycles after T0; d_oe=1 and d_out=$5A after edge T0+3.
- WAIT_STATES=3: write $33 to $0020 with d_in=$33 held through the wait -> later read returns $33. Second cycle_start during WAIT -> bus_err=1, first access still completes.
- Assert reset during WAIT of a write of $77 to $0030 (prior content $11) -> rdy=1, d_oe=0, hit=0, bus_err=0 immediately. Subsequent read of $0030 returns $11.
- Top boundary: BASE_ADDR=16'hE000, WINDOW_SIZE=16'h2000 -> read $FFFF hits (index $7FF); read $DFFF misses.
